ct_ciu_bmb_resp: RTL and testbench

- Barrier-manager responder. It is the far end of the per-cluster barrier request interface.
- Accepts one arbitrated barrier request at a time (valid, master id, 9-bit request bus) and returns a grant.
- Waits until every bus transaction outstanding at grant time has drained.
- Then pulses a completion back to the originating PIU (0-3), selected by master id.
- Sits in the CIU between the barrier request interface and the four PIU completion inputs.

---
 rtl/ct_ciu_bmb_pkg.sv | 22 ++
 rtl/ct_ciu_bmb_trans_cnt.sv | 43 ++++
 rtl/ct_ciu_bmb_resp.sv | 147 ++++++++++++++
 tb/tb_ct_ciu_bmb_resp.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ct_ciu_bmb_pkg.sv
// Shared definitions for the CIU barrier-manager responder: FSM encoding, request-bus
// field layout and the number of PIU completion targets.
package ct_ciu_bmb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StDrain = 2'b01,
        StResp  = 2'b10
    } bmb_state_e;

    localparam int unsigned BarTypeLsb = 0;
    localparam int unsigned BarTypeMsb = 1;
    localparam int unsigned BarTagLsb  = 2;
    localparam int unsigned BarTagMsb  = 8;
    localparam int unsigned ReqBusW    = BarTagMsb + 1;
    localparam int unsigned MidNum     = 4;

    function automatic logic [BarTagMsb-BarTagLsb:0] bar_tag(input logic [ReqBusW-1:0] bus);
        return bus[BarTagMsb:BarTagLsb];
    endfunction

endpackage

// File: rtl/ct_ciu_bmb_trans_cnt.sv
// Up/down counter of outstanding bus transactions. snap_o is the count that a barrier
// granted this cycle must wait for: completions this cycle count, new issues do not.
module ct_ciu_bmb_trans_cnt #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] snap_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign snap_o = cnt_q - CNT_W'(dec_i);

    // Counting beyond the range is a bus-side protocol error; no wrap protection.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(inc_i && !dec_i && (cnt_q == '1)));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec_i && !inc_i && (cnt_q == '0)));

endmodule

// File: rtl/ct_ciu_bmb_resp.sv
// Barrier-manager responder: grants one barrier, drains transactions outstanding at grant,
// then pulses completion to the PIU named by the master id. Watchdog: CT_CIU_BMB_TIMEOUT_EN.
module ct_ciu_bmb_resp
    import ct_ciu_bmb_pkg::*;
#(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned TO_W  = 10
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst_b,
    input  logic               ciu_icg_en,
    input  logic               pad_yy_icg_scan_en,
    input  logic               bmbif_xx_bar_req,
    input  logic [2:0]         bmbif_xx_mid,
    input  logic [ReqBusW-1:0] bmbif_xx_req_bus,
    input  logic               ebiu_bmb_trans_inc,
    input  logic               ebiu_bmb_trans_dec,
    output logic               xx_bmbif_bar_grant,
    output logic               bmb_piu0_xx_cmplt,
    output logic               bmb_piu1_xx_cmplt,
    output logic               bmb_piu2_xx_cmplt,
    output logic               bmb_piu3_xx_cmplt,
    output logic [ReqBusW-1:0] bmb_xx_cmplt_bus,
    output logic               bmb_xx_busy,
    output logic               bmb_xx_bar_timeout
);

    bmb_state_e         state_q, state_d;
    logic [2:0]         mid_q, mid_d;
    logic [ReqBusW-1:0] bus_q, bus_d, cmplt_bus_q, cmplt_bus_d;
    logic [CNT_W-1:0]   drain_q, drain_d, snap, cnt;
    logic [MidNum-1:0]  cmplt_q, cmplt_d;
    logic               grant, busy, clk_en, wd_fire;

    assign busy  = (state_q != StIdle);
    assign grant = bmbif_xx_bar_req && (state_q == StIdle);
    // Clock gate (module enable | local enable | scan override) expressed as a flop enable.
    assign clk_en = ciu_icg_en | pad_yy_icg_scan_en | bmbif_xx_bar_req | busy
                  | ebiu_bmb_trans_inc | ebiu_bmb_trans_dec;

    ct_ciu_bmb_trans_cnt #(
        .CNT_W (CNT_W)
    ) u_trans_cnt (
        .clk_i  (forever_cpuclk),
        .rst_ni (cpurst_b),
        .en_i   (clk_en),
        .inc_i  (ebiu_bmb_trans_inc),
        .dec_i  (ebiu_bmb_trans_dec),
        .cnt_o  (cnt),
        .snap_o (snap)
    );

`ifdef CT_CIU_BMB_TIMEOUT_EN
    logic [TO_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;

    assign wd_fire = (state_q == StDrain) && (wd_q == '1);

    always_comb begin
        wd_d = wd_q;
        to_d = to_q | wd_fire;
        if (grant) begin
            wd_d = '0;
        end else if (state_q == StDrain) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else if (clk_en) begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign bmb_xx_bar_timeout = to_q;
`else
    logic [TO_W-1:0] wd_unused;
    assign wd_unused          = '0;
    assign wd_fire            = 1'b0;
    assign bmb_xx_bar_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mid_d   = mid_q;
        bus_d   = bus_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StDrain;
                    mid_d   = bmbif_xx_mid;
                    bus_d   = bmbif_xx_req_bus;
                    drain_d = snap;
                end
            end
            StDrain: begin
                if ((drain_q == '0) || wd_fire) begin
                    state_d = StResp;
                end else if (ebiu_bmb_trans_dec) begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Outputs are registered: decode them from the next state.
        for (int unsigned n = 0; n < MidNum; n++) begin
            cmplt_d[n] = (state_d == StResp) && (mid_q == 3'(n));
        end
        cmplt_bus_d = (state_d == StResp) ? bus_q : '0;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= StIdle;
            mid_q       <= '0;
            bus_q       <= '0;
            drain_q     <= '0;
            cmplt_q     <= '0;
            cmplt_bus_q <= '0;
        end else if (clk_en) begin
            state_q     <= state_d;
            mid_q       <= mid_d;
            bus_q       <= bus_d;
            drain_q     <= drain_d;
            cmplt_q     <= cmplt_d;
            cmplt_bus_q <= cmplt_bus_d;
        end
    end

    logic [CNT_W-1:0] cnt_unused;
    assign cnt_unused = cnt;

    assign xx_bmbif_bar_grant = grant;
    assign bmb_piu0_xx_cmplt  = cmplt_q[0];
    assign bmb_piu1_xx_cmplt  = cmplt_q[1];
    assign bmb_piu2_xx_cmplt  = cmplt_q[2];
    assign bmb_piu3_xx_cmplt  = cmplt_q[3];
    assign bmb_xx_cmplt_bus   = cmplt_bus_q;
    assign bmb_xx_busy        = busy;

endmodule

// File: tb/tb_ct_ciu_bmb_resp.sv
// Directed bench for ct_ciu_bmb_resp: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_ct_ciu_bmb_resp;

`ifdef CT_CIU_BMB_TIMEOUT_EN
    localparam int unsigned ToW = 4;
`else
    localparam int unsigned ToW = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_b;
    logic       icg_en, scan_en, req, inc, dec;
    logic [2:0] mid;
    logic [8:0] req_bus;
    logic       grant, c0, c1, c2, c3, busy, tmo;
    logic [8:0] cbus;
    logic [3:0] cm;

    int n_tests = 0;
    int n_fail  = 0;

    assign cm = {c3, c2, c1, c0};

    always #5 clk = ~clk;

    ct_ciu_bmb_resp #(
        .CNT_W (6),
        .TO_W  (ToW)
    ) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_b),
        .ciu_icg_en         (icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .bmbif_xx_bar_req   (req),
        .bmbif_xx_mid       (mid),
        .bmbif_xx_req_bus   (req_bus),
        .ebiu_bmb_trans_inc (inc),
        .ebiu_bmb_trans_dec (dec),
        .xx_bmbif_bar_grant (grant),
        .bmb_piu0_xx_cmplt  (c0),
        .bmb_piu1_xx_cmplt  (c1),
        .bmb_piu2_xx_cmplt  (c2),
        .bmb_piu3_xx_cmplt  (c3),
        .bmb_xx_cmplt_bus   (cbus),
        .bmb_xx_busy        (busy),
        .bmb_xx_bar_timeout (tmo)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic g, input logic [3:0] c,
                              input logic [8:0] b, input logic bz);
        @(negedge clk);
        check_eq({tag, ".grant"}, 32'(grant), 32'(g));
        check_eq({tag, ".cmplt"}, 32'(cm), 32'(c));
        check_eq({tag, ".bus"}, 32'(cbus), 32'(b));
        check_eq({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic [2:0] m, input logic [8:0] b);
        req     = r;
        mid     = m;
        req_bus = b;
    endtask

    initial begin
        logic seen;
        int   lat;
        rst_b = 1'b0; icg_en = 1'b0; scan_en = 1'b0;
        inc = 1'b0; dec = 1'b0;
        set_req(1'b0, 3'd0, 9'h0);
        cyc(); cyc();
        expect_out("reset", 1'b0, 4'b0000, 9'h000, 1'b0);
        check_eq("reset.timeout", 32'(tmo), 32'd0);
        cyc();
        rst_b = 1'b1;

        // Empty counter: grant T, cmplt to PIU2 at T+2 only.
        cyc(); set_req(1'b1, 3'd2, 9'h0A5);
        expect_out("idle.T", 1'b1, 4'b0000, 9'h000, 1'b0);
        cyc(); set_req(1'b0, 3'd0, 9'h0);
        expect_out("idle.T1", 1'b0, 4'b0000, 9'h000, 1'b1);
        cyc();
        expect_out("idle.T2", 1'b0, 4'b0100, 9'h0A5, 1'b1);
        cyc();
        expect_out("idle.T3", 1'b0, 4'b0000, 9'h000, 1'b0);

        // Three outstanding: cmplt two cycles after the third dec.
        for (int i = 0; i < 3; i++) begin
            cyc(); inc = 1'b1;
        end
        cyc(); inc = 1'b0; set_req(1'b1, 3'd1, 9'h1F3);
        expect_out("drain.grant", 1'b1, 4'b0000, 9'h000, 1'b0);
        cyc(); set_req(1'b0, 3'd0, 9'h0);
        expect_out("drain.wait", 1'b0, 4'b0000, 9'h000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(); dec = 1'b1;
            cyc(); dec = 1'b0;
            expect_out($sformatf("drain.dec%0d", i), 1'b0, 4'b0000, 9'h000, 1'b1);
        end
        cyc();
        expect_out("drain.resp", 1'b0, 4'b0010, 9'h1F3, 1'b1);
        cyc();
        expect_out("drain.done", 1'b0, 4'b0000, 9'h000, 1'b0);

        // cnt=2, grant alongside inc+dec: snapshot 1, one later dec releases.
        cyc(); inc = 1'b1;
        cyc();
        cyc(); inc = 1'b1; dec = 1'b1; set_req(1'b1, 3'd0, 9'h003);
        expect_out("bnd.grant", 1'b1, 4'b0000, 9'h000, 1'b0);
        cyc(); inc = 1'b0; dec = 1'b0; set_req(1'b0, 3'd0, 9'h0);
        cyc(); cyc();
        expect_out("bnd.hold", 1'b0, 4'b0000, 9'h000, 1'b1);
        cyc(); dec = 1'b1;
        cyc(); dec = 1'b0;
        expect_out("bnd.zero", 1'b0, 4'b0000, 9'h000, 1'b1);
        cyc();
        expect_out("bnd.resp", 1'b0, 4'b0001, 9'h003, 1'b1);
        cyc(); dec = 1'b1;  // retire the post-barrier transaction
        cyc(); dec = 1'b0;

        // Back-to-back with req held: grants at T and T+3.
        cyc(); set_req(1'b1, 3'd0, 9'h100);
        expect_out("b2b.T", 1'b1, 4'b0000, 9'h000, 1'b0);
        cyc(); set_req(1'b1, 3'd3, 9'h0FF);
        expect_out("b2b.T1", 1'b0, 4'b0000, 9'h000, 1'b1);
        cyc();
        expect_out("b2b.T2", 1'b0, 4'b0001, 9'h100, 1'b1);
        cyc();
        expect_out("b2b.T3", 1'b1, 4'b0000, 9'h000, 1'b0);
        cyc(); set_req(1'b0, 3'd0, 9'h0);
        expect_out("b2b.T4", 1'b0, 4'b0000, 9'h000, 1'b1);
        cyc();
        expect_out("b2b.T5", 1'b0, 4'b1000, 9'h0FF, 1'b1);

        // Illegal mid: granted and drained, bus echoed, no pulse.
        cyc(); cyc(); set_req(1'b1, 3'd5, 9'h055);
        expect_out("mid5.T", 1'b1, 4'b0000, 9'h000, 1'b0);
        cyc(); set_req(1'b0, 3'd0, 9'h0);
        cyc();
        expect_out("mid5.T2", 1'b0, 4'b0000, 9'h055, 1'b1);
        cyc();
        expect_out("mid5.T3", 1'b0, 4'b0000, 9'h000, 1'b0);

        // Reset during DRAIN drops the barrier.
        cyc(); inc = 1'b1;
        cyc(); inc = 1'b0; set_req(1'b1, 3'd1, 9'h011);
        cyc(); set_req(1'b0, 3'd0, 9'h0);
        cyc();
        expect_out("rst.drain", 1'b0, 4'b0000, 9'h000, 1'b1);
        #2 rst_b = 1'b0;
        #1 check_eq("rst.busy_async", 32'(busy), 32'd0);
        cyc(); rst_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            seen = seen | (|cm) | busy;
        end
        check_eq("rst.no_cmplt", 32'(seen), 32'd0);

`ifdef CT_CIU_BMB_TIMEOUT_EN
        // One transaction never drains: watchdog forces RESP.
        cyc(); inc = 1'b1;
        cyc(); inc = 1'b0; set_req(1'b1, 3'd3, 9'h1AA);
        expect_out("to.grant", 1'b1, 4'b0000, 9'h000, 1'b0);
        lat = 0;
        seen = 1'b0;
        set_req(1'b0, 3'd0, 9'h0);
        while (!seen && lat < 40) begin
            cyc();
            lat++;
            @(negedge clk);
            seen = c3;
        end
        check_eq("to.fired", 32'(seen), 32'd1);
        check_eq("to.latency", 32'(lat), 32'd17);
        check_eq("to.bus", 32'(cbus), 32'h1AA);
        cyc(); cyc(); cyc();
        check_eq("to.sticky", 32'(tmo), 32'd1);
`else
        lat = 0;
        check_eq("no_to.tied", 32'(tmo), 32'(lat));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
